dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's instruction and data ports; completes every access the CPU initiates on iaddr/idata and daddr/dwdata/dwe/drdata.
- Reads are combinational, so the CPU fetch and MEM stages see data in the same cycle. Byte-lane writes commit on the clock edge.
- Decodes a small MMIO window containing:
  - a free-running cycle counter,
  - a console TX FIFO with a valid/ready drain port,
  - a status register.
- Sits at the top level beside the cpu and is driven by the bench.

Parameters:
- MEM_WORDS, 4096: RAM depth in 32-bit words. Must be a power of 2. RAM occupies byte addresses 0 to MEM_WORDS*4-1.
- FIFO_DEPTH, 8: console FIFO entries. Must be a power of 2, at most 16.
- MMIO_BASE, 32'hFFFF_0000: base byte address of the MMIO window.
- INIT_FILE, "": hex file loaded into RAM at elaboration. Empty string means no load.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; reset==0 sampled at posedge clk resets
- iaddr  in  32  instruction byte address
- idata  out  32  instruction word
- daddr  in  32  data byte address
- dwdata  in  32  write data; lane k is bits [8k+7:8k]
- dwe  in  4  per-byte write enables; 4'b0000 means read
- drdata  out  32  read data
- con_valid  out  1  FIFO head valid
- con_data  out  8  FIFO head byte
- con_ready  in  1  sink accepts head this cycle

Behaviour:
- **Address decode** (daddr[1:0] and iaddr[1:0] are ignored; accesses are word-aligned):
  - RAM hit: address < MEM_WORDS*4. Word index is addr[log2(MEM_WORDS)+1:2].
  - MMIO hit, offset = daddr - MMIO_BASE:
    - 0x0 CYCLE
    - 0x4 CON_TX
    - 0x8 CON_STAT
  - Any other address: reads return 0; writes are ignored.
- **idata:** combinational RAM read at iaddr. Returns 0 if iaddr is outside RAM.
- **drdata:** combinational and independent of dwe.
  - RAM: stored word.
  - CYCLE: current counter value.
  - CON_TX: 0.
  - CON_STAT: {24'b0, count[3:0], 1'b0, ovf, empty, full}.
- **RAM write:** at posedge when reset==1, for each k with dwe[k]==1, byte k of the addressed word <= dwdata lane k. Other lanes are unchanged. A read of the same word in the same cycle returns the old value.
- **CYCLE counter:**
  - 32-bit; 0 on reset; +1 every non-reset cycle; wraps 32'hFFFF_FFFF -> 0.
  - Read-only; writes are ignored.
- **CON_TX push:** a write with dwe[0]==1 pushes dwdata[7:0]. dwe[3:1] are don't-care.
  - The push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky ovf <= 1.
- **Pop:** occurs when con_valid && con_ready.
  - con_valid = !empty.
  - con_data = head byte.
  - No bypass: a push into an empty FIFO is visible on con_valid the following cycle.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. Order is preserved.
- **CON_STAT write:** with dwe[0]==1 and dwdata[2]==1, clears ovf. If a dropped push coincides with the clear, the drop wins and ovf stays 1. Other bits are read-only.
- **Pointers:** wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- **Reset (reset==0 at posedge)** takes priority over everything:
  - CYCLE = 0, FIFO emptied (pointers and count = 0), ovf = 0.
  - con_valid = 0 from the next cycle; con_data is don't-care while !con_valid.
  - All writes and pushes in a reset cycle are ignored.
  - RAM contents are preserved; a reset mid-stream discards queued bytes.
- **Outputs after reset:** drdata and idata reflect current RAM contents, or 0 for unmapped addresses. con_valid = 0.

Decomposition:
- Shared package `dmem_pkg` holds:
  - MMIO offset constants: OFF_CYCLE = 0x0, OFF_CON_TX = 0x4, OFF_CON_STAT = 0x8.
  - CON_STAT bit positions: FULL = 0, EMPTY = 1, OVF = 2, CNT = 7:4.
  - Default MMIO_BASE.
- One sub-module, `sync_fifo`, parameterised width/depth with push/pop/full/empty/count. It is reused for future UART/debug queues.
- RAM array, decode and counter stay in dmem_responder.

Test Plan:
1. **Reset and counter:**
   - Stimulus: hold reset=0 for 3 cycles, release, idle 10 cycles, then read daddr=FFFF_0000.
   - Required: drdata=10. con_valid=0 throughout. CON_STAT read = 32'h0000_0002 (empty).
2. **Byte-lane write:**
   - Stimulus: write 32'h1122_3344 to 0x40 with dwe=4'hF; then write 32'hAABB_CCDD to 0x40 with dwe=4'b0101.
   - Required: a read of 0x40 returns 32'h11BB_33DD. An unmapped read at 0x8000_0000 returns 0.
3. **FIFO ordering:**
   - Stimulus: with con_ready=0, push 0x41, 0x42, 0x43 to FFFF_0004; then raise con_ready.
   - Required: con_data sequence 41, 42, 43 on consecutive cycles, then con_valid=0. CON_STAT count goes 3 -> 0.
4. **Overflow:**
   - Stimulus: with con_ready=0, push 9 bytes (0x00..0x08) at FIFO_DEPTH=8.
   - Required:
     - CON_STAT = 32'h0000_0085 (count 8, full, ovf).
     - After draining, the bytes seen are 00..07; 0x08 is lost.
     - Writing 0x4 to CON_STAT clears ovf.
5. **Full with simultaneous push and pop:**
   - Stimulus: with the FIFO full, con_ready=1 and push 0x5A in the same cycle.
   - Required: the push is accepted, count stays 8, ovf stays 0, and 0x5A is the 8th byte out after the current head.
6. **Reset mid-operation:**
   - Stimulus: with 4 bytes queued, CYCLE=500 and RAM[0x40]=32'hDEAD_BEEF, assert reset=0 for one cycle while also writing 0x40.
   - Required: con_valid=0 and CYCLE restarts at 0 the cycle after release. RAM[0x40] is still 32'hDEAD_BEEF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder and its MMIO window.
package dmem_pkg;

    // MMIO register byte offsets from the window base
    localparam logic [31:0] OFF_CYCLE    = 32'h0000_0000;
    localparam logic [31:0] OFF_CON_TX   = 32'h0000_0004;
    localparam logic [31:0] OFF_CON_STAT = 32'h0000_0008;

    // CON_STAT bit positions
    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 4;
    localparam int unsigned STAT_CNT_MSB = 7;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        RegNone,
        RegCycle,
        RegConTx,
        RegConStat
    } mmio_reg_e;

    // Word-granular decode of an offset into the MMIO window; low two bits are ignored.
    function automatic mmio_reg_e decode_mmio(input logic [31:0] off);
        mmio_reg_e reg_sel;
        reg_sel = RegNone;
        if (off[31:2] == OFF_CYCLE[31:2]) begin
            reg_sel = RegCycle;
        end else if (off[31:2] == OFF_CON_TX[31:2]) begin
            reg_sel = RegConTx;
        end else if (off[31:2] == OFF_CON_STAT[31:2]) begin
            reg_sel = RegConStat;
        end
        return reg_sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted only
// when a pop happens in the same cycle. No read bypass: data written this cycle
// becomes visible at the head on the next cycle.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [Width-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [Width-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally (Depth is a power of 2)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only written on an accepted push
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU instruction and data ports: combinational
// reads, byte-lane writes on the clock edge, and a small MMIO window with a cycle
// counter, console TX FIFO and status register.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]     mem [MEM_WORDS];

    logic            i_hit, d_hit;
    logic [AW-1:0]   i_idx, d_idx;
    logic [31:0]     mmio_off;
    mmio_reg_e       mmio_reg;

    logic [31:0]     cycle_q, cycle_d;
    logic            ovf_q, ovf_d;

    logic            push_req, pop_req, drop, ovf_clr;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [4:0]      cnt_ext;
    logic [31:0]     stat;

    // Address decode; RAM takes priority should the MMIO window ever overlap it
    assign i_hit    = ((iaddr >> (AW + 2)) == 32'd0);
    assign d_hit    = ((daddr >> (AW + 2)) == 32'd0);
    assign i_idx    = iaddr[AW+1:2];
    assign d_idx    = daddr[AW+1:2];
    assign mmio_off = daddr - MMIO_BASE;
    assign mmio_reg = d_hit ? RegNone : decode_mmio(mmio_off);

    assign cnt_ext = 5'(fifo_count);

    // Status word assembly
    always_comb begin
        stat                             = '0;
        stat[STAT_FULL]                  = fifo_full;
        stat[STAT_EMPTY]                 = fifo_empty;
        stat[STAT_OVF]                   = ovf_q;
        stat[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt_ext[3:0];
    end

    // Combinational instruction and data read paths
    always_comb begin
        idata  = i_hit ? mem[i_idx] : '0;
        drdata = '0;
        if (d_hit) begin
            drdata = mem[d_idx];
        end else begin
            unique case (mmio_reg)
                RegCycle:   drdata = cycle_q;
                RegConStat: drdata = stat;
                default:    drdata = '0;
            endcase
        end
    end

    // Byte-lane RAM write; RAM is never cleared by reset
    always_ff @(posedge clk) begin
        if (reset && d_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (dwe[k]) begin
                    mem[d_idx][8*k +: 8] <= dwdata[8*k +: 8];
                end
            end
        end
    end

    // Console push/pop requests, drop detection and sticky overflow next-state
    always_comb begin
        push_req = reset && (mmio_reg == RegConTx) && dwe[0];
        pop_req  = con_valid && con_ready;
        drop     = push_req && fifo_full && !pop_req;
        ovf_clr  = (mmio_reg == RegConStat) && dwe[0] && dwdata[STAT_OVF];
        cycle_d  = cycle_q + 32'd1;
        ovf_d    = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        // A drop in the same cycle as a clear leaves the flag set
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Cycle counter and overflow flag with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_con_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push_req),
        .wdata_i (dwdata[7:0]),
        .pop_i   (pop_req),
        .rdata_o (con_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign con_valid = !fifo_empty;

    logic unused_bits;
    assign unused_bits = ^{iaddr[1:0], mmio_off, cnt_ext[4]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

    localparam logic [31:0] A_CYC  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX   = 32'hFFFF_0004;
    localparam logic [31:0] A_STAT = 32'hFFFF_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iaddr, idata, daddr, dwdata, drdata;
    logic [3:0]  dwe;
    logic        con_valid, con_ready;
    logic [7:0]  con_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .MEM_WORDS  (4096),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (32'hFFFF_0000),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iaddr     (iaddr),
        .idata     (idata),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dwe       (dwe),
        .drdata    (drdata),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
        daddr  = addr;
        dwdata = data;
        dwe    = we;
        cyc();
        dwe    = 4'h0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] val);
        daddr = addr;
        dwe   = 4'h0;
        #1;
        val = drdata;
    endtask

    logic [31:0] v;
    logic [7:0]  exp_b;

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; iaddr = '0; daddr = '0; dwdata = '0; dwe = '0; con_ready = 1'b0;

        // 1. Reset and counter
        repeat (3) cyc();
        check_eq("rst_con_valid", 32'(con_valid), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("idle_con_valid", 32'(con_valid), 32'd0);
            cyc();
        end
        rd(A_CYC, v);  check_eq("cycle_10", v, 32'd10);
        rd(A_STAT, v); check_eq("stat_reset", v, 32'h0000_0002);

        // 2. Byte-lane write, read-old-in-write-cycle, unmapped reads
        wr(32'h40, 32'h1122_3344, 4'hF);
        daddr = 32'h40; dwdata = 32'hAABB_CCDD; dwe = 4'b0101;
        #1 check_eq("read_old_same_cycle", drdata, 32'h1122_3344);
        cyc();
        dwe = 4'h0;
        rd(32'h40, v); check_eq("lane_merge", v, 32'h11BB_33DD);
        iaddr = 32'h40; #1 check_eq("idata_ram", idata, 32'h11BB_33DD);
        rd(32'h8000_0000, v); check_eq("unmapped_d", v, 32'h0);
        iaddr = 32'h8000_0000; #1 check_eq("unmapped_i", idata, 32'h0);
        rd(A_TX, v); check_eq("con_tx_reads_0", v, 32'h0);

        // 3. FIFO ordering, no bypass
        daddr = A_TX; dwdata = 32'h41; dwe = 4'h1;
        #1 check_eq("no_bypass", 32'(con_valid), 32'd0);
        cyc();
        dwe = 4'h0;
        wr(A_TX, 32'h42, 4'h1);
        wr(A_TX, 32'h43, 4'h1);
        rd(A_STAT, v); check_eq("stat_cnt3", v, 32'h0000_0030);
        con_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("drain3_valid", 32'(con_valid), 32'd1);
            check_eq("drain3_data", 32'(con_data), 32'h41 + 32'(i));
            cyc();
        end
        check_eq("drain3_empty", 32'(con_valid), 32'd0);
        con_ready = 1'b0;
        rd(A_STAT, v); check_eq("stat_cnt0", v, 32'h0000_0002);

        // 4. Overflow then clear
        for (int i = 0; i < 9; i++) wr(A_TX, 32'(i), 4'h1);
        rd(A_STAT, v); check_eq("stat_ovf_full", v, 32'h0000_0085);
        check_eq("head_00", 32'(con_data), 32'h00);
        wr(A_STAT, 32'h4, 4'h1);
        rd(A_STAT, v); check_eq("stat_ovf_clr", v, 32'h0000_0081);

        // 5. Full with simultaneous push and pop
        con_ready = 1'b1; daddr = A_TX; dwdata = 32'h5A; dwe = 4'h1;
        #1 check_eq("full_head_00", 32'(con_data), 32'h00);
        cyc();
        dwe = 4'h0;
        rd(A_STAT, v); check_eq("stat_pushpop", v, 32'h0000_0081);
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'(i + 1) : 8'h5A;
            check_eq("drain8_valid", 32'(con_valid), 32'd1);
            check_eq("drain8_data", 32'(con_data), 32'(exp_b));
            cyc();
        end
        check_eq("drain8_empty", 32'(con_valid), 32'd0);
        con_ready = 1'b0;

        // 6. Reset mid-operation
        for (int i = 0; i < 4; i++) wr(A_TX, 32'hA0 + 32'(i), 4'h1);
        wr(32'h40, 32'hDEAD_BEEF, 4'hF);
        rd(A_CYC, v);
        if (v < 32'd500) repeat (500 - v) cyc();
        rd(A_CYC, v); check_eq("cycle_500", v, 32'd500);
        check_eq("pre_rst_valid", 32'(con_valid), 32'd1);
        reset = 1'b0; daddr = 32'h40; dwdata = 32'h1234_5678; dwe = 4'hF;
        cyc();
        reset = 1'b1; dwe = 4'h0;
        check_eq("post_rst_valid", 32'(con_valid), 32'd0);
        rd(A_CYC, v);  check_eq("post_rst_cycle0", v, 32'd0);
        rd(32'h40, v); check_eq("ram_kept", v, 32'hDEAD_BEEF);
        rd(A_STAT, v); check_eq("post_rst_stat", v, 32'h0000_0002);
        cyc();
        rd(A_CYC, v);  check_eq("post_rst_cycle1", v, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
